// File: rtl/pipelined_datapath_if.sv
// Micro-op issue, result and debug-read bus between the decode unit, the
// execute datapath and the write-back stage.
interface pipelined_datapath_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [AW-1:0]     addr_a;
  logic [AW-1:0]     addr_b;
  logic [AW-1:0]     addr_d;
  logic [DATA_W-1:0] immed;
  logic              y_sel;
  logic              write;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] w_out;
  logic              zero_out;
  logic              ovf_out;
  logic [AW-1:0]     dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  // Issuing side: decode/control unit plus the result consumer.
  modport master (
    output in_valid, op, addr_a, addr_b, addr_d, immed, y_sel, write,
    output out_ready, dbg_addr,
    input  in_ready, out_valid, w_out, zero_out, ovf_out, dbg_data
  );

  // Datapath side.
  modport slave (
    input  in_valid, op, addr_a, addr_b, addr_d, immed, y_sel, write,
    input  out_ready, dbg_addr,
    output in_ready, out_valid, w_out, zero_out, ovf_out, dbg_data
  );
endinterface

// File: rtl/pipelined_datapath.sv
// Two-stage execute datapath: register read / operand select (stage R),
// ALU and result register (stage X), with a result bypass from stage X and
// a global stall on result back-pressure.
module pipelined_datapath #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_datapath_if.slave  bus
);

  localparam int unsigned AW   = $clog2(NUM_REGS);
  localparam int unsigned SH_W = $clog2(DATA_W);
  localparam int unsigned MSB  = DATA_W - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Stage X state
  logic              x_valid;
  logic [DATA_W-1:0] x_a;
  logic [DATA_W-1:0] x_y;
  logic [3:0]        x_op;
  logic [AW-1:0]     x_addr_d;
  logic              x_write;

  logic              stall;
  logic              x_dest_live;
  logic              wr_en;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] opnd_y;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;

  // Result not taken by the consumer freezes the whole pipe.
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  // A stage-X op whose destination will really be written (reg 0 discarded).
  assign x_dest_live = x_valid && x_write && !(ZERO_REG && (x_addr_d == '0));
  assign wr_en       = x_dest_live && !stall;

  // Register-bank reads with hardwired zero register.
  assign rd_a = (ZERO_REG && (bus.addr_a == '0)) ? '0 : regs[bus.addr_a];
  assign rd_b = (ZERO_REG && (bus.addr_b == '0)) ? '0 : regs[bus.addr_b];
  assign bus.dbg_data = (ZERO_REG && (bus.dbg_addr == '0)) ? '0 : regs[bus.dbg_addr];

  // Bypass the live ALU result over a pending register-bank write.
  assign opnd_a = (x_dest_live && (x_addr_d == bus.addr_a)) ? alu_res : rd_a;
  assign opnd_b = (x_dest_live && (x_addr_d == bus.addr_b)) ? alu_res : rd_b;
  assign opnd_y = bus.y_sel ? opnd_b : bus.immed;

  assign sum   = x_a + x_y;
  assign diff  = x_a - x_y;
  assign shamt = x_y[SH_W-1:0];

  // ALU; reserved opcodes fall through to PASS_Y.
  always_comb begin
    alu_res = x_y;
    alu_ovf = 1'b0;
    case (x_op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (x_a[MSB] == x_y[MSB]) && (sum[MSB] != x_a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (x_a[MSB] != x_y[MSB]) && (diff[MSB] != x_a[MSB]);
      end
      OP_AND:  alu_res = x_a & x_y;
      OP_OR:   alu_res = x_a | x_y;
      OP_XOR:  alu_res = x_a ^ x_y;
      OP_SLL:  alu_res = x_a << shamt;
      OP_SRL:  alu_res = x_a >> shamt;
      OP_SRA:  alu_res = DATA_W'($signed(x_a) >>> shamt);
      OP_SLT:  alu_res = DATA_W'($signed(x_a) < $signed(x_y));
      OP_SLTU: alu_res = DATA_W'(x_a < x_y);
      default: alu_res = x_y;
    endcase
  end

  // Stage R -> X latch; a bubble enters as x_valid = 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_valid  <= 1'b0;
      x_a      <= '0;
      x_y      <= '0;
      x_op     <= '0;
      x_addr_d <= '0;
      x_write  <= 1'b0;
    end else if (!stall) begin
      x_valid  <= bus.in_valid;
      x_a      <= opnd_a;
      x_y      <= opnd_y;
      x_op     <= bus.op;
      x_addr_d <= bus.addr_d;
      x_write  <= bus.write;
    end
  end

  // Result register and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.w_out     <= '0;
      bus.zero_out  <= 1'b0;
      bus.ovf_out   <= 1'b0;
    end else if (!stall) begin
      bus.out_valid <= x_valid;
      bus.w_out     <= alu_res;
      bus.zero_out  <= (alu_res == '0);
      bus.ovf_out   <= alu_ovf;
    end
  end

  // Register bank write-back from stage X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[x_addr_d] <= alu_res;
    end
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed self-checking bench for pipelined_datapath (DATA_W=32, 32 regs).
module tb_pipelined_datapath;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  pipelined_datapath_if #(.DATA_W(32), .NUM_REGS(32)) bus ();

  pipelined_datapath #(.DATA_W(32), .NUM_REGS(32), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [31:0] imm, input logic ys,
                       input logic wr);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.addr_a   = a;
    bus.addr_b   = b;
    bus.addr_d   = d;
    bus.immed    = imm;
    bus.y_sel    = ys;
    bus.write    = wr;
  endtask

  // Issue one op alone; on return its result is on w_out.
  task automatic exec_op(input logic [3:0] o, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [31:0] imm, input logic ys,
                         input logic wr);
    drive(o, a, b, d, imm, ys, wr);
    step();
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready);
    else n_pass++;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    exec_op(4'd0, 5'd0, 5'd0, 5'd3, 32'h55, 1'b0, 1'b1);
    n_checks++;
    if (bus.w_out !== 32'h55) $display("FAIL pre_rst_w_out: got %h expected 00000055", bus.w_out);
    else n_pass++;
    // Reset lands while a second op is in flight.
    drive(4'd0, 5'd0, 5'd0, 5'd4, 32'h66, 1'b0, 1'b1);
    step();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_out_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.w_out !== 32'h0) $display("FAIL mid_rst_w_out: got %h expected 00000000", bus.w_out);
    else n_pass++;
    n_checks++;
    if ({bus.zero_out, bus.ovf_out} !== 2'b00)
      $display("FAIL mid_rst_flags: got %b expected 00", {bus.zero_out, bus.ovf_out});
    else n_pass++;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b expected 1", bus.in_ready);
    else n_pass++;
    for (int r = 0; r < 32; r++) begin
      bus.dbg_addr = 5'(r);
      #0.1;
      n_checks++;
      if (bus.dbg_data !== 32'h0) $display("FAIL rst_reg%0d: got %h expected 00000000", r, bus.dbg_data);
      else n_pass++;
    end
    step();
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL rst_discard_out_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_add();
    drive(4'd0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL add_latency_n1: got %b expected 0", bus.out_valid);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL add_out_valid: got %b expected 1", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.w_out !== 32'd5) $display("FAIL add_w_out: got %h expected 00000005", bus.w_out);
    else n_pass++;
    n_checks++;
    if (bus.zero_out !== 1'b0) $display("FAIL add_zero: got %b expected 0", bus.zero_out);
    else n_pass++;
    bus.dbg_addr = 5'd1;
    #1;
    n_checks++;
    if (bus.dbg_data !== 32'd5) $display("FAIL add_r1: got %h expected 00000005", bus.dbg_data);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL add_bubble: got %b expected 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(4'd0, 5'd0, 5'd0, 5'd1, 32'd7, 1'b0, 1'b1);
    step();
    drive(4'd0, 5'd1, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1);
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.w_out !== 32'd7 || bus.out_valid !== 1'b1)
      $display("FAIL b2b_first: got %h/%b expected 00000007/1", bus.w_out, bus.out_valid);
    else n_pass++;
    step();
    n_checks++;
    if (bus.w_out !== 32'd14 || bus.out_valid !== 1'b1)
      $display("FAIL b2b_bypass: got %h/%b expected 0000000e/1", bus.w_out, bus.out_valid);
    else n_pass++;
    bus.dbg_addr = 5'd2;
    #1;
    n_checks++;
    if (bus.dbg_data !== 32'd14) $display("FAIL b2b_r2: got %h expected 0000000e", bus.dbg_data);
    else n_pass++;
    step();
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    drive(4'd0, 5'd0, 5'd0, 5'd4, 32'h11, 1'b0, 1'b1);
    step();
    drive(4'd0, 5'd0, 5'd0, 5'd5, 32'h22, 1'b0, 1'b1);
    step();
    drive(4'd0, 5'd0, 5'd0, 5'd6, 32'h33, 1'b0, 1'b1);
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready);
    else n_pass++;
    step();
    step();
    step();
    n_checks++;
    if (bus.w_out !== 32'h11 || bus.out_valid !== 1'b1)
      $display("FAIL stall_hold: got %h/%b expected 00000011/1", bus.w_out, bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready_held: got %b expected 0", bus.in_ready);
    else n_pass++;
    bus.dbg_addr = 5'd5;
    #1;
    n_checks++;
    if (bus.dbg_data !== 32'h0) $display("FAIL stall_r5_unchanged: got %h expected 00000000", bus.dbg_data);
    else n_pass++;
    bus.dbg_addr = 5'd6;
    #1;
    n_checks++;
    if (bus.dbg_data !== 32'h0) $display("FAIL stall_r6_unchanged: got %h expected 00000000", bus.dbg_data);
    else n_pass++;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL unstall_in_ready: got %b expected 1", bus.in_ready);
    else n_pass++;
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.w_out !== 32'h22 || bus.out_valid !== 1'b1)
      $display("FAIL stream_second: got %h/%b expected 00000022/1", bus.w_out, bus.out_valid);
    else n_pass++;
    bus.dbg_addr = 5'd5;
    #1;
    n_checks++;
    if (bus.dbg_data !== 32'h22) $display("FAIL stream_r5: got %h expected 00000022", bus.dbg_data);
    else n_pass++;
    step();
    n_checks++;
    if (bus.w_out !== 32'h33 || bus.out_valid !== 1'b1)
      $display("FAIL stream_third: got %h/%b expected 00000033/1", bus.w_out, bus.out_valid);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL stream_drain: got %b expected 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_arith();
    exec_op(4'd0, 5'd0, 5'd0, 5'd7, 32'h7FFF_FFFF, 1'b0, 1'b1);
    exec_op(4'd0, 5'd7, 5'd0, 5'd0, 32'd1, 1'b0, 1'b0);
    n_checks++;
    if (bus.w_out !== 32'h8000_0000 || bus.ovf_out !== 1'b1)
      $display("FAIL add_ovf: got %h/%b expected 80000000/1", bus.w_out, bus.ovf_out);
    else n_pass++;
    exec_op(4'd0, 5'd0, 5'd0, 5'd8, 32'hFFFF_FFFF, 1'b0, 1'b1);
    exec_op(4'd0, 5'd0, 5'd0, 5'd9, 32'd1, 1'b0, 1'b1);
    exec_op(4'd8, 5'd8, 5'd9, 5'd0, 32'd0, 1'b1, 1'b0);
    n_checks++;
    if (bus.w_out !== 32'd1) $display("FAIL slt: got %h expected 00000001", bus.w_out);
    else n_pass++;
    exec_op(4'd9, 5'd8, 5'd9, 5'd0, 32'd0, 1'b1, 1'b0);
    n_checks++;
    if (bus.w_out !== 32'd0 || bus.zero_out !== 1'b1)
      $display("FAIL sltu: got %h/%b expected 00000000/1", bus.w_out, bus.zero_out);
    else n_pass++;
    exec_op(4'd0, 5'd0, 5'd0, 5'd10, 32'h8000_0000, 1'b0, 1'b1);
    exec_op(4'd7, 5'd10, 5'd0, 5'd0, 32'd4, 1'b0, 1'b0);
    n_checks++;
    if (bus.w_out !== 32'hF800_0000 || bus.ovf_out !== 1'b0)
      $display("FAIL sra: got %h/%b expected f8000000/0", bus.w_out, bus.ovf_out);
    else n_pass++;
    exec_op(4'd6, 5'd10, 5'd0, 5'd0, 32'd4, 1'b0, 1'b0);
    n_checks++;
    if (bus.w_out !== 32'h0800_0000) $display("FAIL srl: got %h expected 08000000", bus.w_out);
    else n_pass++;
    exec_op(4'd5, 5'd9, 5'd0, 5'd0, 32'd31, 1'b0, 1'b0);
    n_checks++;
    if (bus.w_out !== 32'h8000_0000) $display("FAIL sll: got %h expected 80000000", bus.w_out);
    else n_pass++;
    exec_op(4'd1, 5'd10, 5'd0, 5'd0, 32'd1, 1'b0, 1'b0);
    n_checks++;
    if (bus.w_out !== 32'h7FFF_FFFF || bus.ovf_out !== 1'b1)
      $display("FAIL sub_ovf: got %h/%b expected 7fffffff/1", bus.w_out, bus.ovf_out);
    else n_pass++;
    exec_op(4'd1, 5'd9, 5'd9, 5'd0, 32'd0, 1'b1, 1'b0);
    n_checks++;
    if (bus.w_out !== 32'd0 || bus.zero_out !== 1'b1 || bus.ovf_out !== 1'b0)
      $display("FAIL sub_zero: got %h/%b/%b expected 00000000/1/0", bus.w_out, bus.zero_out, bus.ovf_out);
    else n_pass++;
    exec_op(4'd2, 5'd8, 5'd0, 5'd0, 32'h0000_00F0, 1'b0, 1'b0);
    n_checks++;
    if (bus.w_out !== 32'h0000_00F0) $display("FAIL and: got %h expected 000000f0", bus.w_out);
    else n_pass++;
    exec_op(4'd4, 5'd8, 5'd0, 5'd0, 32'h0000_FFFF, 1'b0, 1'b0);
    n_checks++;
    if (bus.w_out !== 32'hFFFF_0000) $display("FAIL xor: got %h expected ffff0000", bus.w_out);
    else n_pass++;
    exec_op(4'd3, 5'd10, 5'd0, 5'd0, 32'h0000_0001, 1'b0, 1'b0);
    n_checks++;
    if (bus.w_out !== 32'h8000_0001) $display("FAIL or: got %h expected 80000001", bus.w_out);
    else n_pass++;
    exec_op(4'd12, 5'd8, 5'd0, 5'd0, 32'h0000_1234, 1'b0, 1'b0);
    n_checks++;
    if (bus.w_out !== 32'h0000_1234) $display("FAIL reserved_pass_y: got %h expected 00001234", bus.w_out);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    exec_op(4'd0, 5'd0, 5'd0, 5'd0, 32'd9, 1'b0, 1'b1);
    n_checks++;
    if (bus.w_out !== 32'd9) $display("FAIL zr_w_out: got %h expected 00000009", bus.w_out);
    else n_pass++;
    bus.dbg_addr = 5'd0;
    #1;
    n_checks++;
    if (bus.dbg_data !== 32'd0) $display("FAIL zr_dbg: got %h expected 00000000", bus.dbg_data);
    else n_pass++;
    drive(4'd0, 5'd0, 5'd0, 5'd0, 32'd9, 1'b0, 1'b1);
    step();
    drive(4'd0, 5'd0, 5'd0, 5'd11, 32'd0, 1'b1, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    n_checks++;
    if (bus.w_out !== 32'd0 || bus.zero_out !== 1'b1)
      $display("FAIL zr_no_bypass: got %h/%b expected 00000000/1", bus.w_out, bus.zero_out);
    else n_pass++;
    bus.dbg_addr = 5'd11;
    #1;
    n_checks++;
    if (bus.dbg_data !== 32'd0) $display("FAIL zr_r11: got %h expected 00000000", bus.dbg_data);
    else n_pass++;
    step();
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.addr_a    = 5'd0;
    bus.addr_b    = 5'd0;
    bus.addr_d    = 5'd0;
    bus.immed     = 32'd0;
    bus.y_sel     = 1'b0;
    bus.write     = 1'b0;
    bus.out_ready = 1'b1;
    bus.dbg_addr  = 5'd0;
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_arith();
    test_zero_reg();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
